// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared encodings for the counter and timer family.
//   DIR_UP / DIR_DN     : values of the dir input (count up / count down)
//   MODE_WRAP / MODE_SAT: values of the sat input (wrap modulo / saturate)
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/updown_next_calc.sv
// -----------------------------------------------------------------------------
// updown_next_calc
// Purely combinational next-count computation for the up/down modulo counter.
// Works out the value the counter would take if it counted this cycle, and
// whether that count crosses a boundary.
//
// Ports:
//   q        in  WIDTH   current count (always 0 .. MAX_VAL)
//   dir      in  1       1 = up, 0 = down
//   sat      in  1       0 = wrap modulo MAX_VAL+1, 1 = saturate at rails
//   step     in  STEP_W  requested increment, clamped to MAX_VAL
//   q_next   out WIDTH   candidate next count
//   cross_up out 1       up count went past MAX_VAL
//   cross_dn out 1       down count went below 0
// -----------------------------------------------------------------------------
module updown_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int STEP_W  = 4
) (
  input  logic [WIDTH-1:0]  q,
  input  logic              dir,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  q_next,
  output logic              cross_up,
  output logic              cross_dn
);

  // One extra bit so q + s never overflows before the boundary compare.
  localparam int             W1      = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_EXT = W1'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_EXT = W1'(MAX_VAL + 1);

  // Effective step: a step larger than the whole range is treated as the
  // range itself, which keeps every count to at most one wrap.
  function automatic logic [WIDTH:0] clamp_step(input logic [STEP_W-1:0] st);
    logic [WIDTH:0] st_ext;
    st_ext = W1'(st);
    return (st_ext > MAX_EXT) ? MAX_EXT : st_ext;
  endfunction

  // Result of a crossing: the rail in saturate mode, the wrapped value otherwise.
  function automatic logic [WIDTH-1:0] sat_or_wrap(input logic           mode,
                                                   input logic [WIDTH:0] wrapped,
                                                   input logic [WIDTH:0] rail);
    logic [WIDTH:0] pick;
    pick = (mode == MODE_SAT) ? rail : wrapped;
    return pick[WIDTH-1:0];
  endfunction

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_wrap;
  logic [WIDTH-1:0] dn_plain;

  always_comb begin
    s        = clamp_step(step);
    q_ext    = W1'(q);
    up_sum   = q_ext + s;
    // Only used when s > q, so the result lies in 0 .. MAX_VAL.
    dn_wrap  = q_ext + MOD_EXT - s;
    // Only used when s <= q, so s fits in WIDTH bits.
    dn_plain = q - s[WIDTH-1:0];

    q_next   = q;
    cross_up = 1'b0;
    cross_dn = 1'b0;

    if (dir == DIR_UP) begin
      if (up_sum > MAX_EXT) begin
        // Also covers saturated hold: q == MAX_VAL with s > 0.
        cross_up = 1'b1;
        q_next   = sat_or_wrap(sat, up_sum - MOD_EXT, MAX_EXT);
      end else begin
        q_next   = up_sum[WIDTH-1:0];
      end
    end else begin
      if (s <= q_ext) begin
        q_next   = dn_plain;
      end else begin
        cross_dn = 1'b1;
        q_next   = sat_or_wrap(sat, dn_wrap, '0);
      end
    end
  end

endmodule : updown_next_calc

// File: rtl/updown_counter_mod.sv
// -----------------------------------------------------------------------------
// updown_counter_mod
// Parametrised up/down modulo counter with run-time wrap/saturate selection,
// per-cycle step size, synchronous parallel load and sticky boundary flags.
//
// Ports:
//   clk       in  1       rising-edge clock
//   arst      in  1       synchronous active-high reset
//   en        in  1       count enable
//   dir       in  1       1 = up, 0 = down
//   sat       in  1       0 = wrap, 1 = saturate
//   step      in  STEP_W  increment per enabled cycle (0 = hold)
//   load      in  1       parallel load, beats en
//   load_val  in  WIDTH   load value, clamped to MAX_VAL
//   clr_flags in  1       clears ovf/udf (a same-cycle crossing wins)
//   q         out WIDTH   registered count
//   tc        out 1       terminal count for the current direction (comb)
//   evt       out 1       one-cycle pulse aligned with a crossing's result
//   ovf       out 1       sticky up-crossing flag
//   udf       out 1       sticky down-crossing flag
// -----------------------------------------------------------------------------
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              dir,
  input  logic              sat,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  q,
  output logic              tc,
  output logic              evt,
  output logic              ovf,
  output logic              udf
);

  if (MAX_VAL < 1 || MAX_VAL > (2**WIDTH) - 1 || STEP_W < 1 || STEP_W > WIDTH) begin : g_param_check
    $fatal(1, "updown_counter_mod: illegal parameters WIDTH=%0d MAX_VAL=%0d STEP_W=%0d",
           WIDTH, MAX_VAL, STEP_W);
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_Q) ? MAX_Q : v;
  endfunction

  logic [WIDTH-1:0] cnt_p1;
  logic             evt_p1;
  logic             ovf_p1;
  logic             udf_p1;

  logic [WIDTH-1:0] q_next;
  logic             cross_up;
  logic             cross_dn;
  logic             count_take;
  logic             ovf_set;
  logic             udf_set;

  updown_next_calc #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP_W  (STEP_W)
  ) u_next (
    .q        (cnt_p1),
    .dir      (dir),
    .sat      (sat),
    .step     (step),
    .q_next   (q_next),
    .cross_up (cross_up),
    .cross_dn (cross_dn)
  );

  // A crossing only counts when the count is actually applied (load wins).
  assign count_take = en & ~load;
  assign ovf_set    = count_take & cross_up;
  assign udf_set    = count_take & cross_dn;

  // ---- stage p1: count, event and flag registers ----
  always_ff @(posedge clk) begin
    if (arst) begin
      cnt_p1 <= '0;
      evt_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      udf_p1 <= 1'b0;
    end else begin
      if (load) begin
        cnt_p1 <= clamp_load(load_val);
      end else if (en) begin
        cnt_p1 <= q_next;
      end
      evt_p1 <= ovf_set | udf_set;
      ovf_p1 <= ovf_set | (ovf_p1 & ~clr_flags);
      udf_p1 <= udf_set | (udf_p1 & ~clr_flags);
    end
  end

  assign q   = cnt_p1;
  assign evt = evt_p1;
  assign ovf = ovf_p1;
  assign udf = udf_p1;
  assign tc  = (dir == DIR_UP) ? (cnt_p1 == MAX_Q) : (cnt_p1 == '0);

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
module tb_updown_counter_mod;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;
  localparam int STEP_W  = 3;

  logic              clk = 1'b0;
  logic              arst = 1'b0;
  logic              en = 1'b0;
  logic              dir = 1'b1;
  logic              sat = 1'b0;
  logic [STEP_W-1:0] step = '0;
  logic              load = 1'b0;
  logic [WIDTH-1:0]  load_val = '0;
  logic              clr_flags = 1'b0;
  logic [WIDTH-1:0]  q;
  logic              tc;
  logic              evt;
  logic              ovf;
  logic              udf;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  int m_q   = 0;
  int m_evt = 0;
  int m_ovf = 0;
  int m_udf = 0;

  updown_counter_mod #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .STEP_W  (STEP_W)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .en        (en),
    .dir       (dir),
    .sat       (sat),
    .step      (step),
    .load      (load),
    .load_val  (load_val),
    .clr_flags (clr_flags),
    .q         (q),
    .tc        (tc),
    .evt       (evt),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  // Model: plain integer arithmetic on the counting rules.
  always @(posedge clk) begin : model
    int s, v, nq, cu, cd;
    cu = 0;
    cd = 0;
    nq = m_q;
    if (arst) begin
      m_q   <= 0;
      m_evt <= 0;
      m_ovf <= 0;
      m_udf <= 0;
    end else begin
      if (load) begin
        v  = int'(load_val);
        nq = (v > MAX_VAL) ? MAX_VAL : v;
      end else if (en) begin
        s = int'(step);
        if (s > MAX_VAL) s = MAX_VAL;
        if (dir) begin
          v = m_q + s;
          if (v > MAX_VAL) begin
            cu = 1;
            nq = sat ? MAX_VAL : (v % (MAX_VAL + 1));
          end else nq = v;
        end else begin
          v = m_q - s;
          if (v < 0) begin
            cd = 1;
            nq = sat ? 0 : (v + MAX_VAL + 1);
          end else nq = v;
        end
      end
      m_q   <= nq;
      m_evt <= cu | cd;
      m_ovf <= cu ? 1 : (clr_flags ? 0 : m_ovf);
      m_udf <= cd ? 1 : (clr_flags ? 0 : m_udf);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_q",   int'(q),   m_q);
      chk("cyc_evt", int'(evt), m_evt);
      chk("cyc_ovf", int'(ovf), m_ovf);
      chk("cyc_udf", int'(udf), m_udf);
      chk("cyc_tc",  int'(tc),  dir ? int'(m_q == MAX_VAL) : int'(m_q == 0));
    end
  end

  // Advance one edge; inputs set afterwards are stable well before the next.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int evt_cnt;

  initial begin
    // Reset
    arst = 1'b1; dir = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd6;
    tick();
    arst = 1'b0; en = 1'b0; load = 1'b0;
    chk_en = 1'b1;
    chk("rst_q",   int'(q),   0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_udf", int'(udf), 0);
    chk("rst_evt", int'(evt), 0);
    chk("rst_tc_up", int'(tc), 0);
    dir = 1'b0; #1;
    chk("rst_tc_dn", int'(tc), 1);

    // Wrap up, 12 edges from 0
    dir = 1'b1; en = 1'b1; step = 3'd1; sat = 1'b0;
    evt_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (evt) evt_cnt++;
      if (i == 10) begin
        chk("wrap_up_q0",  int'(q),   0);
        chk("wrap_up_evt", int'(evt), 1);
      end
    end
    chk("wrap_up_q",    int'(q),   2);
    chk("wrap_up_ovf",  int'(ovf), 1);
    chk("wrap_up_udf",  int'(udf), 0);
    chk("wrap_up_nevt", evt_cnt,   1);

    // clr_flags alone
    en = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("clr_alone_ovf", int'(ovf), 0);

    // Saturate up
    load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0;
    chk("sat_load_q", int'(q), 7);
    en = 1'b1; step = 3'd4; sat = 1'b1; dir = 1'b1;
    tick();
    chk("sat_q",   int'(q),   9);
    chk("sat_ovf", int'(ovf), 1);
    chk("sat_tc",  int'(tc),  1);
    chk("sat_evt", int'(evt), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold_q",   int'(q),   9);
      chk("sat_hold_evt", int'(evt), 1);
    end

    // Wrap down
    en = 1'b0; load = 1'b1; load_val = 4'd2;
    tick();
    load = 1'b0;
    dir = 1'b0; step = 3'd3; sat = 1'b0; en = 1'b1;
    tick();
    chk("wrap_dn_q",   int'(q),   9);
    chk("wrap_dn_udf", int'(udf), 1);
    chk("wrap_dn_evt", int'(evt), 1);
    step = 3'd7;
    tick();
    chk("dn7_q",   int'(q),   2);
    chk("dn7_evt", int'(evt), 0);

    // step = 0 holds
    step = 3'd0;
    tick();
    chk("step0_q",   int'(q),   2);
    chk("step0_evt", int'(evt), 0);

    // Load rules
    en = 1'b0; load = 1'b1; load_val = 4'd13;
    tick();
    chk("load_clamp_q", int'(q), 9);
    en = 1'b1; dir = 1'b1; step = 3'd1; load_val = 4'd4;
    tick();
    load = 1'b0; en = 1'b0;
    chk("load_over_en_q", int'(q), 4);
    chk("load_no_evt",    int'(evt), 0);

    // Flag races: set beats clear
    clr_flags = 1'b1;
    tick();
    chk("clr_both_udf", int'(udf), 0);
    clr_flags = 1'b0; load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1; step = 3'd1; sat = 1'b0; clr_flags = 1'b1;
    tick();
    chk("race_q",   int'(q),   0);
    chk("race_ovf", int'(ovf), 1);
    en = 1'b0;
    tick();
    clr_flags = 1'b0;
    chk("race_clr_ovf", int'(ovf), 0);

    // Reset while counting
    en = 1'b1; dir = 1'b0; step = 3'd1;
    tick();
    chk("pre_rst_udf", int'(udf), 1);
    en = 1'b0; load = 1'b1; load_val = 4'd5;
    tick();
    chk("pre_rst_q", int'(q), 5);
    arst = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1;
    tick();
    arst = 1'b0; load = 1'b0;
    chk("mid_rst_q",   int'(q),   0);
    chk("mid_rst_udf", int'(udf), 0);
    chk("mid_rst_evt", int'(evt), 0);

    // Mixed vectors, checked by the per-cycle model compare
    for (int i = 0; i < 60; i++) begin
      en        = ($urandom_range(0, 3) != 0);
      dir       = $urandom_range(0, 1);
      sat       = $urandom_range(0, 1);
      step      = STEP_W'($urandom_range(0, 7));
      load      = ($urandom_range(0, 7) == 0);
      load_val  = WIDTH'($urandom_range(0, 15));
      clr_flags = ($urandom_range(0, 5) == 0);
      tick();
    end

    en = 1'b0; load = 1'b0; clr_flags = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_updown_counter_mod
